// File: rtl/ddr_rd_fetch.sv
// DDR read fetcher: splits a configured byte region into 4KB-safe bursts and
// buffers returned beats in a FWFT FIFO. Define DDR_RD_FETCH_STATS_EN for stat counters.
module ddr_rd_fetch #(
   parameter int unsigned DDR_ADDR_LEN = 32,
   parameter int unsigned SINGLE_LEN   = 24,
   parameter int unsigned DATA_LEN     = 32,
   parameter int unsigned BURST_MAX    = 16,
   parameter int unsigned FIFO_DEPTH   = 64,
   parameter int unsigned FIFO_AW      = 6
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ddr_conf,
   input  logic [DDR_ADDR_LEN-1:0]   ddr_st_addr,
   input  logic [SINGLE_LEN-1:0]     ddr_len,
   output logic [DDR_ADDR_LEN-1:0]   m_araddr,
   output logic [7:0]                m_arlen,
   output logic                      m_arvalid,
   input  logic                      m_arready,
   input  logic [DATA_LEN*16-1:0]    m_rdata,
   input  logic                      m_rvalid,
   input  logic                      m_rlast,
   output logic                      ddr_fifo_empty,
   input  logic                      ddr_fifo_req,
   output logic [DATA_LEN*16-1:0]    ddr_fifo_data,
   output logic                      idle,
   output logic                      conf_err
`ifdef DDR_RD_FETCH_STATS_EN
   ,
   output logic [31:0]               stat_beats,
   output logic [31:0]               stat_stall
`endif
);

   localparam int unsigned BEAT_W = DATA_LEN * 16;
   localparam int unsigned BL_W   = SINGLE_LEN - 5;
   localparam int unsigned CNT_W  = FIFO_AW + 1;
   localparam int unsigned BW     = 9;
   localparam int unsigned SUM_W  = FIFO_AW + 4;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_ADDR, S_WAIT} state_t;

   state_t                  r_state, w_state_nxt;
   logic [DDR_ADDR_LEN-1:0] r_addr, r_araddr;
   logic [BL_W-1:0]         r_beats_left;
   logic [BW-1:0]           r_burst;
   logic [CNT_W-1:0]        r_outstanding, r_count;
   logic [7:0]              r_arlen;
   logic                    r_arvalid, r_idle, r_conf_err, r_drop, r_empty;
   logic [BEAT_W-1:0]       r_mem [FIFO_DEPTH];
   logic [FIFO_AW-1:0]      r_wr_ptr, r_rd_ptr;

   logic [SINGLE_LEN:0]     w_len_round;
   logic [6:0]              w_to_4k;
   logic [BW-1:0]           w_burst;
   logic                    w_credit_ok, w_accept, w_conf_bad, w_calc_go, w_ar_hs;
   logic                    w_beat, w_push, w_pop, w_ovf;
   logic [CNT_W-1:0]        w_out_nxt, w_cnt_nxt;
   logic                    w_unused;

   assign w_unused    = ^{m_rlast, ddr_st_addr[5:0]};
   assign w_len_round = {1'b0, ddr_len} + (SINGLE_LEN+1)'(63);
   assign w_to_4k     = 7'd64 - {1'b0, r_addr[11:6]};

   // Burst = min(beats left, BURST_MAX, beats up to the next 4KB boundary)
   always_comb begin
      w_burst = BW'(BURST_MAX);
      if (BW'(w_to_4k) < w_burst) w_burst = BW'(w_to_4k);
      if (r_beats_left < BL_W'(w_burst)) w_burst = BW'(r_beats_left);
   end

   assign w_credit_ok = (SUM_W'(r_count) + SUM_W'(r_outstanding) + SUM_W'(w_burst))
                        <= SUM_W'(FIFO_DEPTH);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_conf_bad  = 1'b0;
      w_calc_go   = 1'b0;
      w_ar_hs     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (ddr_conf) begin
               if (r_outstanding == '0) begin
                  w_accept = 1'b1;
                  if (ddr_len != '0) w_state_nxt = S_CALC;
               end else begin
                  w_conf_bad = 1'b1;
               end
            end
         end
         S_CALC: begin
            if (w_credit_ok) begin
               w_calc_go   = 1'b1;
               w_state_nxt = S_ADDR;
            end
         end
         S_ADDR: begin
            if (m_arready) begin
               w_ar_hs     = 1'b1;
               w_state_nxt = (r_beats_left != BL_W'(r_burst)) ? S_CALC : S_WAIT;
            end
         end
         S_WAIT: begin
            if (r_outstanding == '0) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (ddr_conf && (r_state != S_IDLE)) w_conf_bad = 1'b1;
   end

   // After a reset, stale beats of an abandoned job are discarded until a new job
   assign w_beat = m_rvalid && !r_drop;
   assign w_pop  = ddr_fifo_req && !r_empty;
   assign w_push = w_beat && ((r_count != CNT_W'(FIFO_DEPTH)) || w_pop);
   assign w_ovf  = w_beat && !w_push;

   always_comb begin
      w_out_nxt = r_outstanding;
      if (w_ar_hs) w_out_nxt = w_out_nxt + CNT_W'(r_burst);
      if (w_beat && (r_outstanding != '0)) w_out_nxt = w_out_nxt - CNT_W'(1);
   end

   always_comb begin
      w_cnt_nxt = r_count;
      if (w_push && !w_pop) w_cnt_nxt = r_count + CNT_W'(1);
      if (w_pop && !w_push) w_cnt_nxt = r_count - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr        <= '0;
         r_beats_left  <= '0;
         r_burst       <= '0;
         r_outstanding <= '0;
         r_araddr      <= '0;
         r_arlen       <= '0;
         r_arvalid     <= 1'b0;
         r_idle        <= 1'b1;
         r_conf_err    <= 1'b0;
         r_drop        <= 1'b1;
      end else begin
         if (w_accept) begin
            r_addr       <= {ddr_st_addr[DDR_ADDR_LEN-1:6], 6'b0};
            r_beats_left <= w_len_round[SINGLE_LEN:6];
            r_drop       <= 1'b0;
         end
         if (w_calc_go) begin
            r_burst   <= w_burst;
            r_araddr  <= r_addr;
            r_arlen   <= 8'(w_burst - BW'(1));
            r_arvalid <= 1'b1;
         end
         if (w_ar_hs) begin
            r_arvalid    <= 1'b0;
            r_beats_left <= r_beats_left - BL_W'(r_burst);
            r_addr       <= r_addr + (DDR_ADDR_LEN'(r_burst) << 6);
         end
         r_outstanding <= w_out_nxt;
         r_idle        <= (w_state_nxt == S_IDLE) && (w_out_nxt == '0);
         r_conf_err    <= r_conf_err | w_conf_bad | w_ovf;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_empty  <= 1'b1;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
         r_count <= w_cnt_nxt;
         r_empty <= (w_cnt_nxt == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= m_rdata;
   end

`ifdef DDR_RD_FETCH_STATS_EN
   logic [31:0] r_stat_beats, r_stat_stall;
   logic        w_stall;

   assign w_stall = ((r_state == S_CALC) && !w_credit_ok) ||
                    ((r_state == S_ADDR) && !m_arready);

   // Saturating activity counters
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stat_beats <= '0;
         r_stat_stall <= '0;
      end else begin
         if (w_push && (r_stat_beats != '1))  r_stat_beats <= r_stat_beats + 32'd1;
         if (w_stall && (r_stat_stall != '1)) r_stat_stall <= r_stat_stall + 32'd1;
      end
   end

   assign stat_beats = r_stat_beats;
   assign stat_stall = r_stat_stall;
`endif

   assign m_araddr       = r_araddr;
   assign m_arlen        = r_arlen;
   assign m_arvalid      = r_arvalid;
   assign ddr_fifo_empty = r_empty;
   assign ddr_fifo_data  = r_empty ? '0 : r_mem[r_rd_ptr];
   assign idle           = r_idle;
   assign conf_err       = r_conf_err;

endmodule
